// File: rtl/ex_pkg.sv
// Shared types and widths for the execute/write-back stage.
// Opcodes, datapath widths and the ID/EX latch layout.
package ex_pkg;

  localparam int DATA_W     = 8;
  localparam int REG_ADDR_W = 3;
  localparam int INSTR_W    = 8;

  typedef enum logic [1:0] {
    OP_MOV  = 2'b00,
    OP_ADDI = 2'b01,
    OP_SLL  = 2'b10,
    OP_JMP  = 2'b11
  } op_e;

  typedef struct packed {
    logic               valid;
    op_e                op;
    logic [INSTR_W-1:0] instr;
    logic [DATA_W-1:0]  operand;
    logic [DATA_W-1:0]  imm;
    logic [DATA_W-1:0]  sht;
  } id_ex_t;

endpackage

// File: rtl/ex_wb_stage_if.sv
// Decode-side inputs and write-back/branch outputs of the execute stage.
// master = decode/fetch side, slave = ex_wb_stage.
interface ex_wb_stage_if;
  import ex_pkg::*;

  logic [INSTR_W-1:0]    Instr_Code_ID;
  logic                  ID_Valid;
  logic                  Stall;
  logic [DATA_W-1:0]     Read_Data;
  logic [DATA_W-1:0]     Imm_Data;
  logic [DATA_W-1:0]     Sht_Data;
  logic [1:0]            opcode;
  logic [REG_ADDR_W-1:0] Write_Reg_Num;
  logic [DATA_W-1:0]     Write_Data;
  logic                  RegWrite;
  logic                  Branch_Taken;
  logic [DATA_W-1:0]     Branch_Offset;

  modport master (
    output Instr_Code_ID, ID_Valid, Stall, Read_Data, Imm_Data, Sht_Data, opcode,
    input  Write_Reg_Num, Write_Data, RegWrite, Branch_Taken, Branch_Offset
  );

  modport slave (
    input  Instr_Code_ID, ID_Valid, Stall, Read_Data, Imm_Data, Sht_Data, opcode,
    output Write_Reg_Num, Write_Data, RegWrite, Branch_Taken, Branch_Offset
  );

endinterface

// File: rtl/ex_alu.sv
// Combinational 8-bit ALU for MOV/ADDI/SLL/JMP.
// Produces the result, destination register and write enable.
module ex_alu
  import ex_pkg::*;
(
  input  op_e                   op,
  input  logic [DATA_W-1:0]     op_a,
  input  logic [DATA_W-1:0]     imm,
  input  logic [5:0]            fields,
  output logic [DATA_W-1:0]     result,
  output logic [REG_ADDR_W-1:0] rd,
  output logic                  wr_en
);

  always_comb begin
    result = '0;
    rd     = fields[5:3];
    wr_en  = 1'b1;
    case (op)
      OP_MOV: begin
        rd     = fields[2:0];
        result = op_a;
      end
      OP_ADDI: result = op_a + imm;
      OP_SLL:  result = op_a << imm[2:0];
      OP_JMP:  wr_en  = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_wb_stage.sv
// Execute + write-back stage: ID/EX latch, ALU, EX/WB register, branch squash.
// Operand forwarding from write-back is built only when EX_FORWARD_EN is defined.
module ex_wb_stage
  import ex_pkg::*;
(
  input logic          Clk,
  input logic          Reset,
  ex_wb_stage_if.slave bus
);

  id_ex_t                id_ex_q;
  id_ex_t                id_ex_d;
  logic [DATA_W-1:0]     id_operand;
  logic [DATA_W-1:0]     op_a;
  logic [DATA_W-1:0]     alu_result;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic                  alu_wr_en;
  logic                  ex_jmp;
  logic                  squash;
  logic                  ex_write;
  logic                  unused_op_bits;

  assign ex_jmp   = id_ex_q.valid && (id_ex_q.op == OP_JMP);
  assign ex_write = id_ex_q.valid && alu_wr_en;
  // Kill the slot entering EX behind a JMP, and the one after while the pulse is out.
  assign squash   = ex_jmp || bus.Branch_Taken;

  assign unused_op_bits = ^id_ex_q.instr[7:6];

`ifdef EX_FORWARD_EN
  assign id_operand = (bus.RegWrite && (bus.Instr_Code_ID[5:3] == bus.Write_Reg_Num))
                      ? bus.Write_Data : bus.Read_Data;
  assign op_a       = (bus.RegWrite && (id_ex_q.instr[5:3] == bus.Write_Reg_Num))
                      ? bus.Write_Data : id_ex_q.operand;
`else
  assign id_operand = bus.Read_Data;
  assign op_a       = id_ex_q.operand;
`endif

  always_comb begin
    id_ex_d         = '0;
    id_ex_d.valid   = bus.ID_Valid && !bus.Stall && !squash;
    id_ex_d.op      = op_e'(bus.opcode);
    id_ex_d.instr   = bus.Instr_Code_ID;
    id_ex_d.operand = id_operand;
    id_ex_d.imm     = bus.Imm_Data;
    id_ex_d.sht     = bus.Sht_Data;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      id_ex_q <= '0;
    end else begin
      id_ex_q <= id_ex_d;
    end
  end

  ex_alu u_alu (
    .op     (id_ex_q.op),
    .op_a   (op_a),
    .imm    (id_ex_q.imm),
    .fields (id_ex_q.instr[5:0]),
    .result (alu_result),
    .rd     (alu_rd),
    .wr_en  (alu_wr_en)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      bus.RegWrite      <= 1'b0;
      bus.Write_Reg_Num <= '0;
      bus.Write_Data    <= '0;
      bus.Branch_Taken  <= 1'b0;
      bus.Branch_Offset <= '0;
    end else begin
      bus.RegWrite      <= ex_write;
      bus.Branch_Taken  <= ex_jmp;
      bus.Branch_Offset <= ex_jmp ? id_ex_q.sht : '0;
      if (ex_write) begin
        bus.Write_Reg_Num <= alu_rd;
        bus.Write_Data    <= alu_result;
      end
    end
  end

endmodule

// File: tb/tb_ex_wb_stage.sv
// Randomized bench for ex_wb_stage against an architectural register/timing model.
// The bench itself plays the register file, updated from the model's expected writes.
module tb_ex_wb_stage;
  import ex_pkg::*;

`ifdef EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int DEPTH = 2048;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  ex_wb_stage_if bus ();

  ex_wb_stage dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int e = 4;

  bit [7:0] rf   [8];
  bit [7:0] arch [8];
  bit       exp_we   [DEPTH];
  bit [2:0] exp_num  [DEPTH];
  bit [7:0] exp_data [DEPTH];
  bit       exp_br   [DEPTH];
  bit [7:0] exp_off  [DEPTH];
  bit       jmp_acc  [DEPTH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", tag, got, want, e - 1);
    end
  endtask

  task automatic check_window(input int w);
    chk("regwrite", bus.RegWrite, exp_we[w]);
    if (exp_we[w]) begin
      chk("wr_num", bus.Write_Reg_Num, exp_num[w]);
      chk("wr_data", bus.Write_Data, exp_data[w]);
    end
    chk("branch", bus.Branch_Taken, exp_br[w]);
    if (exp_br[w]) chk("br_off", bus.Branch_Offset, exp_off[w]);
  endtask

  task automatic drive(input logic [7:0] ins, input logic v, input logic st);
    bus.Instr_Code_ID = ins;
    bus.ID_Valid      = v;
    bus.Stall         = st;
    bus.opcode        = ins[7:6];
    bus.Read_Data     = rf[ins[5:3]];
    bus.Imm_Data      = {{5{ins[2]}}, ins[2:0]};
    bus.Sht_Data      = {{2{ins[5]}}, ins[5:0]};
  endtask

  // One clock: present an instruction, predict its architectural effect, check the window.
  task automatic cycle(input logic [7:0] ins, input logic v, input logic st);
    bit [7:0] a;
    bit [7:0] res;
    bit [2:0] rd;
    int       imm_v;
    drive(ins, v, st);
    if (v && !st && !jmp_acc[e-1] && !jmp_acc[e-2]) begin
      a     = FWD ? arch[ins[5:3]] : rf[ins[5:3]];
      imm_v = ins[2] ? int'(ins[2:0]) - 8 : int'(ins[2:0]);
      rd    = ins[5:3];
      res   = a;
      case (ins[7:6])
        2'b00: rd  = ins[2:0];
        2'b01: res = 8'((int'(a) + imm_v + 256) % 256);
        2'b10: res = 8'((int'(a) * (1 << ins[2:0])) % 256);
        default: ;
      endcase
      if (ins[7:6] == 2'b11) begin
        jmp_acc[e]   = 1'b1;
        exp_br[e+1]  = 1'b1;
        exp_off[e+1] = {{2{ins[5]}}, ins[5:0]};
      end else begin
        exp_we[e+1]   = 1'b1;
        exp_num[e+1]  = rd;
        exp_data[e+1] = res;
        arch[rd]      = res;
      end
    end
    @(posedge Clk);
    e++;
    if (exp_we[e-2]) rf[exp_num[e-2]] = exp_data[e-2];
    @(negedge Clk);
    check_window(e - 1);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(8'h00, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    int ed;
    drive(8'h00, 1'b0, 1'b0);
    Reset = 1'b1;
    repeat (n) begin
      ed = e;
      @(posedge Clk);
      e++;
      if (exp_we[ed-1]) rf[exp_num[ed-1]] = exp_data[ed-1];
      for (int k = ed - 1; k <= ed + 3; k++) jmp_acc[k] = 1'b0;
      for (int k = ed; k <= ed + 3; k++) begin
        exp_we[k] = 1'b0;
        exp_br[k] = 1'b0;
      end
      @(negedge Clk);
      chk("rst_regwrite", bus.RegWrite, 0);
      chk("rst_branch", bus.Branch_Taken, 0);
      chk("rst_wr_num", bus.Write_Reg_Num, 0);
      chk("rst_wr_data", bus.Write_Data, 0);
      chk("rst_br_off", bus.Branch_Offset, 0);
    end
    for (int i = 0; i < 8; i++) arch[i] = rf[i];
    Reset = 1'b0;
  endtask

  task automatic set_reg(input int idx, input logic [7:0] val);
    rf[idx]   = val;
    arch[idx] = val;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) set_reg(i, 8'(i * 17 + 1));
    drive(8'h00, 1'b0, 1'b0);

    // Reset, idle, then reset over a pending write.
    do_reset(2);
    idle(2);
    set_reg(3, 8'h03);
    cycle(8'b00_011_101, 1'b1, 1'b0);
    do_reset(1);
    cycle(8'h00, 1'b0, 1'b0);
    chk("rst_drop", bus.RegWrite, 0);
    idle(1);

    // MOV R5 <- R3
    cycle(8'b00_011_101, 1'b1, 1'b0);
    cycle(8'h00, 1'b0, 1'b0);
    chk("mov_we", bus.RegWrite, 1);
    chk("mov_num", bus.Write_Reg_Num, 5);
    chk("mov_data", bus.Write_Data, 8'h03);
    cycle(8'h00, 1'b0, 1'b0);
    chk("mov_pulse", bus.RegWrite, 0);
    idle(2);

    // ADDI R2,-1 with R2 = 0; SLL R1,3 with R1 = 0x21
    set_reg(2, 8'h00);
    set_reg(1, 8'h21);
    cycle(8'b01_010_111, 1'b1, 1'b0);
    cycle(8'b10_001_011, 1'b1, 1'b0);
    chk("addi_num", bus.Write_Reg_Num, 2);
    chk("addi_data", bus.Write_Data, 8'hFF);
    cycle(8'h00, 1'b0, 1'b0);
    chk("sll_num", bus.Write_Reg_Num, 1);
    chk("sll_data", bus.Write_Data, 8'h08);
    idle(2);

    // ADDI R3,+1 then MOV R0 <- R3
    set_reg(3, 8'h04);
    cycle(8'b01_011_001, 1'b1, 1'b0);
    cycle(8'b00_011_000, 1'b1, 1'b0);
    chk("raw_addi", bus.Write_Data, 8'h05);
    cycle(8'h00, 1'b0, 1'b0);
    chk("raw_mov_num", bus.Write_Reg_Num, 0);
    chk("raw_mov_data", bus.Write_Data, FWD ? 8'h05 : 8'h04);
    idle(2);

    // JMP -2 followed by a MOV that must be squashed
    cycle(8'b11_111_110, 1'b1, 1'b0);
    cycle(8'b00_000_001, 1'b1, 1'b0);
    chk("jmp_taken", bus.Branch_Taken, 1);
    chk("jmp_off", bus.Branch_Offset, 8'hFE);
    cycle(8'h00, 1'b0, 1'b0);
    chk("jmp_pulse", bus.Branch_Taken, 0);
    chk("jmp_sq_a", bus.RegWrite, 0);
    cycle(8'h00, 1'b0, 1'b0);
    chk("jmp_sq_b", bus.RegWrite, 0);
    idle(2);

    // Two stalled cycles, then accepted
    set_reg(3, 8'h5A);
    cycle(8'b00_011_110, 1'b1, 1'b1);
    cycle(8'b00_011_110, 1'b1, 1'b1);
    chk("stall_a", bus.RegWrite, 0);
    cycle(8'b00_011_110, 1'b1, 1'b0);
    chk("stall_b", bus.RegWrite, 0);
    cycle(8'h00, 1'b0, 1'b0);
    chk("stall_we", bus.RegWrite, 1);
    chk("stall_num", bus.Write_Reg_Num, 6);
    chk("stall_data", bus.Write_Data, 8'h5A);
    idle(2);

    // Random traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 96) == 0) begin
        do_reset(1);
      end else begin
        cycle(8'($urandom), ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0));
      end
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
